// File: rtl/umi_pkg.sv
// Shared UMI definitions: arbiter mode encoding and a small one-hot helper.
package umi_pkg;

    localparam logic UMI_ARB_FIXED = 1'b0;
    localparam logic UMI_ARB_RR    = 1'b1;

    localparam int unsigned UMI_ARB_MAX_N = 32;

    // True when v has at most one bit set.
    function automatic logic umi_onehot0(input logic [UMI_ARB_MAX_N-1:0] v);
        return (v & (v - UMI_ARB_MAX_N'(1))) == '0;
    endfunction

endpackage

// File: rtl/umi_arb_prio.sv
// Combinational masked priority picker: first set bit of req at or above the
// one-hot pointer prio, wrapping from N-1 to 0. Result is one-hot or zero.
module umi_arb_prio #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] req_i,
    input  logic [N-1:0] prio_i,
    output logic [N-1:0] gnt_o
);

    logic [2*N-1:0] req2;
    logic [2*N-1:0] thr;
    logic [2*N-1:0] cand;
    logic [2*N-1:0] pick;

    always_comb begin
        req2  = {req_i, req_i};
        // Lower copy keeps bits at/above the pointer; upper copy supplies the wrap.
        thr   = {{N{1'b1}}, ~(prio_i - N'(1))};
        cand  = req2 & thr;
        pick  = cand & (~cand + (2*N)'(1));
        gnt_o = pick[N-1:0] | pick[2*N-1:N];
    end

endmodule

// File: rtl/umi_arbiter.sv
// Round-robin / fixed-priority arbiter feeding a one-hot UMI mux; a grant is held
// until its handshake. Define UMI_ARBITER_CHECK_EN for the sticky error checker.
module umi_arbiter
    import umi_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         mode_i,
    input  logic [N-1:0] mask_i,
    input  logic [N-1:0] umi_in_valid_i,
    output logic [N-1:0] umi_in_ready_o,
    input  logic         umi_out_ready_i,
    output logic [N-1:0] grant_o,
    output logic         error_o
);

    logic [N-1:0] prio_q, prio_d;
    logic [N-1:0] lockgnt_q, lockgnt_d;
    logic         lock_q, lock_d;

    logic [N-1:0] req;
    logic [N-1:0] prio_sel;
    logic [N-1:0] arb_gnt;
    logic [N-1:0] grant;
    logic         hs;

    assign req      = umi_in_valid_i & ~mask_i;
    assign prio_sel = (mode_i == UMI_ARB_RR) ? prio_q : N'(1);

    umi_arb_prio #(
        .N(N)
    ) u_prio (
        .req_i  (req),
        .prio_i (prio_sel),
        .gnt_o  (arb_gnt)
    );

    assign grant          = lock_q ? (lockgnt_q & umi_in_valid_i) : arb_gnt;
    assign hs             = |(grant & umi_in_valid_i) & umi_out_ready_i;
    assign grant_o        = grant;
    assign umi_in_ready_o = grant & {N{umi_out_ready_i}};

    always_comb begin
        prio_d    = prio_q;
        lock_d    = lock_q;
        lockgnt_d = lockgnt_q;
        if (hs) begin
            lock_d    = 1'b0;
            lockgnt_d = '0;
            if (mode_i == UMI_ARB_RR) begin
                prio_d = {grant[N-2:0], grant[N-1]};
            end
        end else if (|grant) begin
            lock_d    = 1'b1;
            lockgnt_d = grant;
        end else begin
            // Nothing granted, or the held requester dropped valid: release.
            lock_d    = 1'b0;
            lockgnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio_q    <= N'(1);
            lock_q    <= 1'b0;
            lockgnt_q <= '0;
        end else begin
            prio_q    <= prio_d;
            lock_q    <= lock_d;
            lockgnt_q <= lockgnt_d;
        end
    end

`ifdef UMI_ARBITER_CHECK_EN
    logic error_q, error_d;
    logic drop;
    logic gnt_ok;

    assign drop    = lock_q & ~|(lockgnt_q & umi_in_valid_i);
    assign gnt_ok  = umi_onehot0(UMI_ARB_MAX_N'(grant));
    assign error_d = error_q | ~gnt_ok | drop;
    assign error_o = error_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end

    always @(posedge clk) begin
        if (!reset) begin
            assert (gnt_ok) else $error("umi_arbiter: grant not one-hot: %b", grant);
            assert (!drop) else $warning("umi_arbiter: locked requester dropped valid");
        end
    end
`else
    assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_umi_arbiter.sv
// Directed scoreboard bench for umi_arbiter (N=4).
module tb_umi_arbiter;

    localparam int unsigned N = 4;
`ifdef UMI_ARBITER_CHECK_EN
    localparam logic CheckEn = 1'b1;
`else
    localparam logic CheckEn = 1'b0;
`endif

    typedef struct {
        logic [N-1:0] grant;
        logic [N-1:0] ready;
        string        tag;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         mode;
    logic [N-1:0] mask;
    logic [N-1:0] valid;
    logic [N-1:0] in_ready;
    logic         out_ready;
    logic [N-1:0] grant;
    logic         error;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    umi_arbiter #(
        .N(N)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .mode_i          (mode),
        .mask_i          (mask),
        .umi_in_valid_i  (valid),
        .umi_in_ready_o  (in_ready),
        .umi_out_ready_i (out_ready),
        .grant_o         (grant),
        .error_o         (error)
    );

    task automatic drive(input logic [N-1:0] v, input logic [N-1:0] m, input logic md,
                         input logic r, input logic [N-1:0] eg, input string tag);
        exp_t e;
        valid     = v;
        mask      = m;
        mode      = md;
        out_ready = r;
        e.grant = eg;
        e.ready = eg & {N{r}};
        e.tag   = tag;
        sb.push_back(e);
        #2;
        e = sb.pop_front();
        checks++;
        assert (grant === e.grant) else begin
            failures++;
            $error("FAIL %s grant: got %b expected %b", e.tag, grant, e.grant);
        end
        checks++;
        assert (in_ready === e.ready) else begin
            failures++;
            $error("FAIL %s umi_in_ready: got %b expected %b", e.tag, in_ready, e.ready);
        end
    endtask

    task automatic step(input logic [N-1:0] v, input logic [N-1:0] m, input logic md,
                        input logic r, input logic [N-1:0] eg, input string tag);
        @(negedge clk);
        drive(v, m, md, r, eg, tag);
    endtask

    task automatic chk_err(input logic exp, input string tag);
        checks++;
        assert (error === exp) else begin
            failures++;
            $error("FAIL %s error: got %b expected %b", tag, error, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        mode      = 1'b0;
        mask      = '0;
        valid     = '0;
        out_ready = 1'b0;
        #1;
        // During reset: fixed-priority result of req even in RR mode.
        drive(4'b1010, 4'b0000, 1'b1, 1'b1, 4'b0010, "rst_fixed");
        drive(4'b1100, 4'b0000, 1'b1, 1'b0, 4'b0100, "rst_fixed2");
        chk_err(1'b0, "err_reset");
        @(negedge clk);
        reset = 1'b0;
        valid = '0;

        // Round-robin rotation with continuous requests.
        step(4'b1111, 4'b0000, 1'b1, 1'b1, 4'b0001, "rr0");
        step(4'b1111, 4'b0000, 1'b1, 1'b1, 4'b0010, "rr1");
        step(4'b1111, 4'b0000, 1'b1, 1'b1, 4'b0100, "rr2");
        step(4'b1111, 4'b0000, 1'b1, 1'b1, 4'b1000, "rr3");
        step(4'b1111, 4'b0000, 1'b1, 1'b1, 4'b0001, "rr4");

        // Fixed priority; pointer (now bit 1) is ignored and preserved.
        step(4'b1010, 4'b0000, 1'b0, 1'b1, 4'b0010, "fx0");
        step(4'b1010, 4'b0000, 1'b0, 1'b1, 4'b0010, "fx1");
        step(4'b1010, 4'b0000, 1'b0, 1'b1, 4'b0010, "fx2");
        step(4'b1000, 4'b0000, 1'b0, 1'b1, 4'b1000, "fx_clr1");

        // RR from pointer bit 1 finds bit 3, pointer wraps to bit 0.
        step(4'b1000, 4'b0000, 1'b1, 1'b1, 4'b1000, "rr_wrap");

        // Backpressure holds the grant.
        step(4'b0011, 4'b0000, 1'b1, 1'b0, 4'b0001, "bp_hold0");
        step(4'b0011, 4'b0000, 1'b1, 1'b0, 4'b0001, "bp_hold1");
        step(4'b0011, 4'b0000, 1'b1, 1'b0, 4'b0001, "bp_hold2");
        step(4'b0011, 4'b0000, 1'b1, 1'b1, 4'b0001, "bp_hs");
        step(4'b0011, 4'b0000, 1'b1, 1'b1, 4'b0010, "bp_next");

        // Masking; a held lock ignores a newly set mask.
        step(4'b0001, 4'b0001, 1'b1, 1'b1, 4'b0000, "mask_rr");
        step(4'b0001, 4'b0001, 1'b0, 1'b1, 4'b0000, "mask_fx");
        step(4'b0001, 4'b0000, 1'b1, 1'b0, 4'b0001, "lock0");
        step(4'b0001, 4'b0001, 1'b1, 1'b0, 4'b0001, "lock0_masked");
        step(4'b0001, 4'b0001, 1'b1, 1'b1, 4'b0001, "lock0_hs");
        step(4'b0001, 4'b0001, 1'b1, 1'b1, 4'b0000, "mask_after");

        // Locked requester drops valid.
        step(4'b0100, 4'b0000, 1'b1, 1'b0, 4'b0100, "lock2");
        step(4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, "drop2");
        chk_err(1'b0, "err_pre");
        step(4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, "idle");
        chk_err(CheckEn, "err_set");
        step(4'b0011, 4'b0000, 1'b1, 1'b1, 4'b0010, "rearb");
        chk_err(CheckEn, "err_sticky");

        // Asynchronous reset in the middle of a lock.
        step(4'b0100, 4'b0000, 1'b1, 1'b0, 4'b0100, "lock2b");
        step(4'b0100, 4'b0000, 1'b1, 1'b0, 4'b0100, "lock2b_hold");
        @(negedge clk);
        reset = 1'b1;
        drive(4'b0101, 4'b0000, 1'b1, 1'b0, 4'b0001, "rst_midlock");
        chk_err(1'b0, "err_rst");
        @(negedge clk);
        reset = 1'b0;
        valid = '0;
        step(4'b0101, 4'b0000, 1'b1, 1'b1, 4'b0001, "post_rst");
        step(4'b0101, 4'b0000, 1'b1, 1'b1, 4'b0100, "post_rst2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
